// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and defaults shared by the data-memory port arbiter.
package mem_arb_pkg;
    localparam int STARVE_MAX_DEF = 4;
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t CPU_ACC = 2'd1;
    localparam state_t PER_ACC = 2'd2;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between the CPU MEM stage and a peripheral master,
// with a bounded number of CPU grants while the peripheral waits.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        pipe_stall,
    input  logic        per_req,
    input  logic        per_we,
    input  logic [31:0] per_addr,
    input  logic [31:0] per_wdata,
    output logic [31:0] per_rdata,
    output logic        per_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d, per_rdata_q, per_rdata_d;
    logic          cpu_req, idle, cpu_acc, per_acc, busy, starved, cpu_go, per_go;

    assign cpu_req = cpu_rd | cpu_wr;
    assign idle    = state_q == IDLE;
    assign cpu_acc = state_q == CPU_ACC;
    assign per_acc = state_q == PER_ACC;
    assign busy    = cpu_acc | per_acc;
    assign starved = per_req && (starve_q == CW'(STARVE_MAX));
    assign cpu_go  = idle && cpu_req && !starved;
    assign per_go  = idle && !cpu_go && per_req;

    always_comb begin
        state_d     = idle ? (cpu_go ? CPU_ACC : per_go ? PER_ACC : IDLE) :
                      (busy && !mem_ready) ? state_q : IDLE;
        starve_d    = per_go ? '0 :
                      (cpu_go && per_req && starve_q != CW'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
        // a simultaneous load and store is treated as a store
        mem_we_d    = cpu_go ? cpu_wr : per_go ? per_we : mem_we_q;
        addr_d      = cpu_go ? cpu_addr : per_go ? per_addr : addr_q;
        wdata_d     = cpu_go ? cpu_wdata : per_go ? per_wdata : wdata_q;
        cpu_rdata_d = (cpu_acc && mem_ready && !mem_we_q) ? mem_rdata : cpu_rdata_q;
        per_rdata_d = (per_acc && mem_ready && !mem_we_q) ? mem_rdata : per_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_we_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            per_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_we_q    <= mem_we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            per_rdata_q <= per_rdata_d;
        end
    end

    assign mem_en     = busy;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_rdata  = cpu_acc ? mem_rdata : cpu_rdata_q;
    assign per_rdata  = per_acc ? mem_rdata : per_rdata_q;
    assign pipe_stall = cpu_req && !(cpu_acc && mem_ready);
    // an access cut short by reset never reports completion
    assign per_done   = per_acc && mem_ready && reset;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; requests queue their expected memory access,
// a negedge monitor checks each completed access against a word-array memory model.
module tb_mem_port_arbiter;
    localparam int SM = 4;
    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} acc_t;

    logic        clk = 1'b0, reset = 1'b0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0, per_req = 1'b0, per_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, per_addr = '0, per_wdata = '0;
    logic [31:0] cpu_rdata, per_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        pipe_stall, per_done, mem_en, mem_we;
    logic [31:0] mem [64];
    logic [31:0] last_cpu = '0, last_per = '0;
    acc_t        exp_cpu[$], exp_per[$];
    int          checks = 0, errors = 0, starve_obs = 0;
    logic        cpu_fin = 1'b0, per_fin = 1'b0;

    assign mem_rdata = mem[mem_addr[7:2]];
    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .pipe_stall(pipe_stall),
        .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
        .per_rdata(per_rdata), .per_done(per_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic missing(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an event expected none or a timeout occurred", name);
    endtask

    task automatic check_acc(input string who, input acc_t e);
        chk({who, "_addr"}, mem_addr, e.addr);
        chk({who, "_we"}, mem_we, e.we);
        chk({who, "_wdata"}, mem_wdata, e.wdata);
    endtask

    // monitor: one completed access per (mem_en & mem_ready) cycle, owner told by per_done
    always @(negedge clk) begin
        acc_t e;
        if (!reset) begin
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
            last_cpu = '0;
            last_per = '0;
            starve_obs = 0;
            cpu_fin = 1'b0;
            per_fin = 1'b0;
        end else begin
            cpu_fin = (cpu_rd | cpu_wr) && !pipe_stall;
            per_fin = per_done;
            if (per_done && !(mem_en && mem_ready)) missing("per_done_spurious");
            if (mem_en && mem_ready) begin
                if (per_done) begin
                    chk("per_cycle_stall", pipe_stall, cpu_rd | cpu_wr);
                    if (exp_per.size() == 0) missing("per_unexpected");
                    else begin
                        e = exp_per.pop_front();
                        check_acc("per", e);
                        if (e.we) mem[e.addr[7:2]] = e.wdata;
                        else begin
                            chk("per_rdata", per_rdata, mem[e.addr[7:2]]);
                            last_per = mem[e.addr[7:2]];
                        end
                        starve_obs = 0;
                    end
                end else begin
                    chk("cpu_done_stall", pipe_stall, 0);
                    if (exp_cpu.size() == 0) missing("cpu_unexpected");
                    else begin
                        e = exp_cpu.pop_front();
                        check_acc("cpu", e);
                        if (e.we) mem[e.addr[7:2]] = e.wdata;
                        else begin
                            chk("cpu_rdata", cpu_rdata, mem[e.addr[7:2]]);
                            last_cpu = mem[e.addr[7:2]];
                        end
                        if (per_req) begin
                            starve_obs++;
                            chk("starve_bound", 32'(starve_obs <= SM + 1), 1);
                        end
                    end
                end
            end else chk("stall_wait", pipe_stall, cpu_rd | cpu_wr);
            if (!mem_en) begin
                chk("cpu_rdata_hold", cpu_rdata, last_cpu);
                chk("per_rdata_hold", per_rdata, last_per);
            end
        end
    end

    task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input int low, output int stalls, output int ens, output logic [31:0] rdat);
        int lowc = 0;
        bit ok = 0;
        stalls = 0;
        ens = 0;
        rdat = '0;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        mem_ready = (low == 0);
        exp_cpu.push_back('{we: wr, addr: a, wdata: d});
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (pipe_stall) stalls++;
            if (mem_en) begin
                ens++;
                chk("hold_addr", mem_addr, a);
                chk("hold_we", mem_we, wr);
                chk("hold_wdata", mem_wdata, d);
                if (!mem_ready) lowc++;
            end
            if (!pipe_stall) begin
                ok = 1;
                rdat = cpu_rdata;
            end else begin
                @(posedge clk); #1;
                mem_ready = (lowc >= low);
            end
        end
        if (!ok) missing("cpu_access_timeout");
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        int st, en, grants, dones, lowc, r;
        bit ok, seen, cpu_act, per_act;
        logic [31:0] rd;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_per_rdata", per_rdata, 0);
        chk("rst_per_done", per_done, 0);
        cpu_rd = 1'b1;
        #1 chk("rst_stall", pipe_stall, 1);
        cpu_rd = 1'b0;
        @(posedge clk); #1 reset = 1'b1;

        cpu_access(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 0, st, en, rd);
        cpu_access(1'b1, 1'b0, 32'h40, 32'h0, 0, st, en, rd);
        chk("rd_stall_cycles", st, 1);
        chk("rd_en_cycles", en, 1);
        chk("rd_data", rd, 32'hDEADBEEF);

        cpu_access(1'b0, 1'b1, 32'h80, 32'h1234, 3, st, en, rd);
        chk("wr_stall_cycles", st, 4);
        chk("wr_en_cycles", en, 4);

        cpu_access(1'b1, 1'b1, 32'hC0, 32'hA5A50001, 1, st, en, rd);
        cpu_access(1'b1, 1'b0, 32'hC0, 32'h0, 0, st, en, rd);
        chk("rdwr_is_write", rd, 32'hA5A50001);

        // peripheral read with a CPU load arriving mid-access
        per_req = 1'b1; per_we = 1'b0; per_addr = 32'h44; per_wdata = '0; mem_ready = 1'b0;
        exp_per.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0});
        @(posedge clk); #1;
        cpu_rd = 1'b1; cpu_addr = 32'h48; cpu_wdata = '0;
        exp_cpu.push_back('{we: 1'b0, addr: 32'h48, wdata: 32'h0});
        st = 0; dones = 0; lowc = 0; ok = 0; seen = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (pipe_stall) st++;
            if (per_done) begin dones++; seen = 1; end
            if (mem_en && !mem_ready) lowc++;
            if (!pipe_stall) ok = 1;
            else begin
                @(posedge clk); #1;
                if (seen) per_req = 1'b0;
                mem_ready = (lowc >= 2);
            end
        end
        if (!ok) missing("mid_timeout");
        chk("mid_per_done_pulses", dones, 1);
        chk("mid_stall_cycles", st, 4);
        @(posedge clk); #1 cpu_rd = 1'b0; mem_ready = 1'b0;

        // both masters held: SM CPU grants per peripheral grant, twice in a row
        cpu_rd = 1'b1; cpu_addr = 32'h10; per_req = 1'b1; per_we = 1'b1; per_addr = 32'h14;
        per_wdata = 32'h0BADF00D; mem_ready = 1'b1;
        for (int i = 0; i < 2 * SM + 1; i++) exp_cpu.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
        for (int i = 0; i < 2; i++) exp_per.push_back('{we: 1'b1, addr: 32'h14, wdata: 32'h0BADF00D});
        for (int rnd = 0; rnd < 2; rnd++) begin
            grants = 0; ok = 0;
            for (int i = 0; i < 60 && !ok; i++) begin
                @(negedge clk);
                if (per_done) ok = 1;
                else if (!pipe_stall) grants++;
                @(posedge clk); #1;
            end
            if (!ok) missing("starve_timeout");
            chk("starve_cpu_grants", grants, SM);
        end
        per_req = 1'b0; ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (!pipe_stall) ok = 1;
            @(posedge clk); #1;
        end
        if (!ok) missing("starve_tail_timeout");
        cpu_rd = 1'b0; mem_ready = 1'b0;

        // reset abandons accesses in flight
        cpu_rd = 1'b1; cpu_addr = 32'h20;
        @(posedge clk); #1;
        @(negedge clk) chk("rstcpu_pre_en", mem_en, 1);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rstcpu_en", mem_en, 0);
        chk("rstcpu_addr", mem_addr, 0);
        chk("rstcpu_stall", pipe_stall, 1);
        cpu_rd = 1'b0; reset = 1'b1;
        per_req = 1'b1; per_we = 1'b0; per_addr = 32'h24;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b0; mem_ready = 1'b1;
        @(negedge clk) chk("rstper_done", per_done, 0);
        @(posedge clk); #1 per_req = 1'b0;
        @(negedge clk);
        chk("rstper_done_after", per_done, 0);
        chk("rstper_en", mem_en, 0);
        @(posedge clk); #1 reset = 1'b1; mem_ready = 1'b0;

        cpu_act = 0; per_act = 0;
        for (int c = 0; c < 3100; c++) begin
            @(posedge clk); #1;
            if (cpu_act && cpu_fin) begin cpu_act = 0; cpu_rd = 1'b0; cpu_wr = 1'b0; end
            if (per_act && per_fin) begin per_act = 0; per_req = 1'b0; end
            if (c < 3000) begin
                if (!cpu_act && $urandom_range(0, 2) == 0) begin
                    r = int'($urandom_range(1, 3));
                    cpu_rd = r[0]; cpu_wr = r[1];
                    cpu_addr = 32'($urandom_range(0, 63)) << 2;
                    cpu_wdata = $urandom;
                    exp_cpu.push_back('{we: cpu_wr, addr: cpu_addr, wdata: cpu_wdata});
                    cpu_act = 1;
                end
                if (!per_act && $urandom_range(0, 3) == 0) begin
                    per_req = 1'b1; per_we = 1'($urandom_range(0, 1));
                    per_addr = 32'($urandom_range(0, 63)) << 2;
                    per_wdata = $urandom;
                    exp_per.push_back('{we: per_we, addr: per_addr, wdata: per_wdata});
                    per_act = 1;
                end
            end
            mem_ready = ($urandom_range(0, 3) != 0);
        end
        chk("drain_cpu_active", cpu_act, 0);
        chk("drain_per_active", per_act, 0);
        chk("drain_cpu_queue", exp_cpu.size(), 0);
        chk("drain_per_queue", exp_per.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
